// File: rtl/sram_mbist_pkg.sv
// Shared definitions for the March C- memory BIST: controller states,
// the per-element operation table and the miscompare counter limit.
package sram_mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         NUM_ELEM  = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);
  localparam logic [7:0] CNT_MAX   = 8'd255;

  // One March element: address direction plus the read/write it performs
  // at every address (read always comes before write when both exist).
  typedef struct packed {
    logic down;
    logic has_rd;
    logic has_wr;
    logic rd_val;
    logic wr_val;
  } elem_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  function automatic elem_t elem_info(input logic [2:0] e);
    elem_t info;
    info = '0;
    case (e)
      3'd0:    info = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
      3'd1:    info = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd2:    info = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd3:    info = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      3'd4:    info = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      3'd5:    info = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sram_mbist_cmp.sv
// Read-compare pipeline: carries expected background, address and element
// alongside each read for RD_LAT cycles, then checks mem_dout on arrival.
module sram_mbist_cmp
  import sram_mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_elem,
  input  logic              rd_exp,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_cnt
);

  // The expected word is always a solid background, so one bit suffices.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
    logic              exp;
  } stage_t;

  stage_t head;
  stage_t tail;
  logic   miscmp;

  logic [ADDR_W-1:0] fail_addr_reg;
  logic [2:0]        fail_elem_reg;
  logic [7:0]        fail_cnt_reg;

  assign head = '{vld: rd_vld, addr: rd_addr, elem: rd_elem, exp: rd_exp};

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    stage_t stage_in;
    stage_t stage_reg;
    if (gi == 0) begin : g_first
      assign stage_in = head;
    end else begin : g_next
      assign stage_in = g_pipe[gi-1].stage_reg;
    end
    // Advance one pipeline stage; reset leaves every slot invalid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_reg <= '0;
      else        stage_reg <= stage_in;
    end
  end

  assign tail   = g_pipe[RD_LAT-1].stage_reg;
  assign miscmp = tail.vld && (mem_dout != {DATA_W{tail.exp}});

  // Record the first failing location and count all miscompares (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
      fail_cnt_reg  <= '0;
    end else if (clr) begin
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
      fail_cnt_reg  <= '0;
    end else if (miscmp) begin
      // The count never returns to zero within a run, so zero marks "first".
      if (fail_cnt_reg == 8'd0) begin
        fail_addr_reg <= tail.addr;
        fail_elem_reg <= tail.elem;
      end
      if (fail_cnt_reg != CNT_MAX) fail_cnt_reg <= fail_cnt_reg + 8'd1;
    end
  end

  assign fail_addr = fail_addr_reg;
  assign fail_elem = fail_elem_reg;
  assign fail_cnt  = fail_cnt_reg;

endmodule

// File: rtl/sram_mbist.sv
// March C- memory BIST controller: sequences one SRAM operation per cycle
// through six elements, then drains the read pipeline and reports results.
module sram_mbist
  import sram_mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int                DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  state_t            state_reg, state_next;
  logic [2:0]        elem_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              phase_reg;   // 0: first op at this address, 1: second
  logic [DRAIN_W-1:0] drain_reg;

  elem_t             cur;
  logic              op_rd;
  logic              op_bg;
  logic              addr_done;
  logic              last_op;
  logic              launch;
  logic [ADDR_W-1:0] op_addr;

  assign cur       = elem_info(elem_reg);
  assign op_rd     = cur.has_rd && !phase_reg;
  assign op_bg     = op_rd ? cur.rd_val : cur.wr_val;
  assign addr_done = !(cur.has_rd && cur.has_wr) || phase_reg;
  assign last_op   = (elem_reg == LAST_ELEM) && (idx_reg == ADDR_LAST) && addr_done;
  assign launch    = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start;
  // Down elements walk the complemented index: 63..0 with no wrap into the next element.
  assign op_addr   = cur.down ? ~idx_reg : idx_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decision; start is only looked at outside RUN/DRAIN.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start)                   state_next = ST_RUN;
      ST_RUN:   if (last_op)                 state_next = ST_DRAIN;
      ST_DRAIN: if (drain_reg == DRAIN_LAST) state_next = ST_DONE;
      ST_DONE:  if (start)                   state_next = ST_RUN;
      default:                               state_next = ST_IDLE;
    endcase
  end

  // Element / address / phase sequencing and drain timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_reg  <= '0;
      idx_reg   <= '0;
      phase_reg <= 1'b0;
      drain_reg <= '0;
    end else if (launch) begin
      elem_reg  <= '0;
      idx_reg   <= '0;
      phase_reg <= 1'b0;
      drain_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      if (!addr_done) begin
        phase_reg <= 1'b1;
      end else begin
        phase_reg <= 1'b0;
        if (idx_reg == ADDR_LAST) begin
          idx_reg <= '0;
          if (elem_reg != LAST_ELEM) elem_reg <= elem_reg + 3'd1;
        end else begin
          idx_reg <= idx_reg + ADDR_W'(1);
        end
      end
    end else if (state_reg == ST_DRAIN) begin
      drain_reg <= drain_reg + DRAIN_W'(1);
    end
  end

  // Status and SRAM drive; the memory port is quiet outside RUN.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (state_reg)
      ST_RUN: begin
        busy     = 1'b1;
        mem_we   = !op_rd;
        mem_addr = op_addr;
        mem_din  = op_rd ? '0 : {DATA_W{op_bg}};
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  sram_mbist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .rd_vld    ((state_reg == ST_RUN) && op_rd),
    .rd_addr   (op_addr),
    .rd_elem   (elem_reg),
    .rd_exp    (op_bg),
    .mem_dout  (mem_dout),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_cnt  (fail_cnt)
  );

  assign pass = (state_reg == ST_DONE) && (fail_cnt == 8'd0);

endmodule

// File: tb/tb_sram_mbist.sv
// Bench for sram_mbist: behavioural SRAM with injectable faults, a March C-
// operation list and result model derived from the algorithm description,
// and a per-cycle compare process.
module tb_sram_mbist;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 64;
  localparam int RD_LAT    = 1;
  localparam int DEPTH     = 64;
  localparam int N_OPS     = 640;
  localparam int DONE_EDGE = N_OPS + RD_LAT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [7:0]        fail_cnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  always #5 clk = ~clk;

  sram_mbist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // ---------------- SRAM model with fault injection ----------------
  // fault_mode 0: none, 1: single stuck-at bit, 2: every read inverted
  int                fault_mode = 0;
  int                f_addr = 0;
  int                f_bit = 0;
  logic              f_val = 1'b0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q = '0;
  logic [ADDR_W-1:0] rd_addr_q = '0;
  logic [DATA_W-1:0] dout_w;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    rd_q      <= mem[mem_addr];
    rd_addr_q <= mem_addr;
  end

  always_comb begin
    dout_w = rd_q;
    if (fault_mode == 1 && int'(rd_addr_q) == f_addr) dout_w[f_bit] = f_val;
    else if (fault_mode == 2) dout_w = ~rd_q;
  end
  assign mem_dout = dout_w;

  function automatic logic [DATA_W-1:0] faulty(input logic [DATA_W-1:0] w, input int a);
    logic [DATA_W-1:0] r;
    r = w;
    if (fault_mode == 1 && a == f_addr) r[f_bit] = f_val;
    else if (fault_mode == 2) r = ~w;
    return r;
  endfunction

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- March C- operation list ----------------
  // Each element: direction and up to two ops (0=w0 1=w1 2=r0 3=r1 -1=none).
  int   el_down [6] = '{0, 0, 0, 1, 1, 0};
  int   el_op   [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
  bit   exp_we   [N_OPS];
  int   exp_addr [N_OPS];
  bit   exp_bg   [N_OPS];
  int   exp_elem [N_OPS];
  int   n_ops = 0;

  task automatic build_ops();
    n_ops = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++)
        for (int p = 0; p < 2; p++)
          if (el_op[e][p] >= 0 && n_ops < N_OPS) begin
            exp_addr[n_ops] = el_down[e] ? (DEPTH - 1 - i) : i;
            exp_we[n_ops]   = (el_op[e][p] < 2);
            exp_bg[n_ops]   = el_op[e][p][0];
            exp_elem[n_ops] = e;
            n_ops++;
          end
  endtask

  // Expected results of one full run against the currently injected fault.
  logic       n_pass;
  int         n_cnt, n_addr, n_elem;
  task automatic compute_expected();
    logic [DATA_W-1:0] mm [DEPTH];
    logic [DATA_W-1:0] w;
    int cnt;
    cnt = 0; n_addr = 0; n_elem = 0;
    for (int k = 0; k < N_OPS; k++) begin
      w = {DATA_W{exp_bg[k]}};
      if (exp_we[k]) mm[exp_addr[k]] = w;
      else if (faulty(mm[exp_addr[k]], exp_addr[k]) != w) begin
        if (cnt == 0) begin n_addr = exp_addr[k]; n_elem = exp_elem[k]; end
        cnt++;
      end
    end
    n_cnt  = (cnt > 255) ? 255 : cnt;
    n_pass = (cnt == 0);
  endtask

  // ---------------- timing model ----------------
  bit   m_active = 0, m_done = 0;
  int   m_k = 0;
  logic e_pass;
  int   e_cnt, e_addr, e_elem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_done <= 0; m_k <= 0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k == DONE_EDGE - 1) begin m_active <= 0; m_done <= 1; end
    end else if (start) begin
      m_active <= 1; m_done <= 0; m_k <= 0;
      e_pass <= n_pass; e_cnt <= n_cnt; e_addr <= n_addr; e_elem <= n_elem;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit prev_rd = 0;
  int prev_addr = 0;
  int prev_elem = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_we", mem_we, 0);
      check("rst_cnt", fail_cnt, 0);
      prev_rd <= 0;
    end else begin
      check("busy", busy, m_active);
      check("done", done, m_done);
      if (m_active && m_k < N_OPS) begin
        check("op_we", mem_we, exp_we[m_k]);
        check("op_addr", mem_addr, exp_addr[m_k]);
        if (exp_we[m_k]) check("op_din", mem_din, {DATA_W{exp_bg[m_k]}});
        if (prev_rd && prev_elem != 5) begin
          check("rw_pair_we", mem_we, 1);
          check("rw_pair_addr", mem_addr, prev_addr);
        end
      end else begin
        check("quiet_we", mem_we, 0);
        check("quiet_addr", mem_addr, 0);
        check("quiet_din", mem_din, 0);
      end
      if (m_active) check("pass_cleared", pass, 0);
      if (!m_active && !m_done) begin
        check("idle_cnt", fail_cnt, 0);
        check("idle_pass", pass, 0);
      end
      if (m_done) begin
        check("res_pass", pass, e_pass);
        check("res_cnt", fail_cnt, e_cnt);
        check("res_addr", fail_addr, e_addr);
        check("res_elem", fail_elem, e_elem);
      end
      prev_rd   <= m_active && m_k < N_OPS && !mem_we;
      prev_addr <= int'(mem_addr);
      prev_elem <= (m_active && m_k < N_OPS) ? exp_elem[m_k] : 0;
    end
  end

  // ---------------- driver ----------------
  task automatic set_fault(input int mode, input int a, input int b, input logic v);
    fault_mode = mode; f_addr = a; f_bit = b; f_val = v;
    compute_expected();
  endtask

  task automatic wait_done(input string name);
    int edges;
    edges = 0;
    while (done !== 1'b1 && edges < 800) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, edges, DONE_EDGE);
    $display("run %s: edges=%0d pass=%0d fail_cnt=%0d fail_addr=%0d fail_elem=%0d",
             name, edges, pass, fail_cnt, fail_addr, fail_elem);
  endtask

  task automatic do_run(input int gap, input string name);
    repeat (gap + 1) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(name);
  endtask

  initial begin
    build_ops();
    check("model_ops", n_ops, 640);
    check("model_m3_first", exp_addr[320], 63);
    check("model_m4_last", exp_addr[575], 0);
    check("model_m5_first", exp_addr[576], 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    rst_n = 1'b1;

    // Fault-free memory
    set_fault(0, 0, 0, 1'b0);
    check("model_clean_pass", n_pass, 1);
    do_run(2, "clean");
    check("clean_pass", pass, 1);
    check("clean_cnt", fail_cnt, 0);

    // addr 5 bit 0 stuck-at-1: fails on r0 reads of M1, M3, M5
    set_fault(1, 5, 0, 1'b1);
    check("model_sa1_cnt", n_cnt, 3);
    check("model_sa1_elem", n_elem, 1);
    do_run(1, "sa1_a5");
    check("sa1_pass", pass, 0);
    check("sa1_elem", fail_elem, 1);
    check("sa1_addr", fail_addr, 5);
    check("sa1_cnt", fail_cnt, 3);

    // addr 63 bit 63 stuck-at-0: fails on r1 reads of M2, M4
    set_fault(1, 63, 63, 1'b0);
    check("model_sa0_cnt", n_cnt, 2);
    do_run(0, "sa0_a63");
    check("sa0_pass", pass, 0);
    check("sa0_elem", fail_elem, 2);
    check("sa0_addr", fail_addr, 63);
    check("sa0_cnt", fail_cnt, 2);

    // Every read corrupted: 320 miscompares, counter saturates
    set_fault(2, 0, 0, 1'b0);
    check("model_sat_cnt", n_cnt, 255);
    do_run(3, "all_bad");
    check("sat_cnt", fail_cnt, 255);
    check("sat_addr", fail_addr, 0);
    check("sat_elem", fail_elem, 1);

    // Reset asserted mid-run
    set_fault(0, 0, 0, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("post_rst_idle", busy, 0);
    do_run(0, "after_rst");
    check("after_rst_pass", pass, 1);

    // start held through a faulty run, then an immediate clean rerun from DONE
    set_fault(1, 5, 0, 1'b1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    wait_done("held");
    check("held_cnt", fail_cnt, 3);
    check("held_addr", fail_addr, 5);
    set_fault(0, 0, 0, 1'b0);
    @(posedge clk); #1;
    check("rerun_busy", busy, 1);
    check("rerun_done", done, 0);
    check("rerun_cnt", fail_cnt, 0);
    check("rerun_addr", fail_addr, 0);
    check("rerun_elem", fail_elem, 0);
    start = 1'b0;
    wait_done("rerun");
    check("rerun_pass", pass, 1);

    // Randomised single stuck-at faults
    for (int r = 0; r < 6; r++) begin
      set_fault($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63),
                1'($urandom_range(0, 1)));
      do_run($urandom_range(0, 4), "rand");
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
